// File: rtl/riscv_regfile_writeback.sv
// riscv_regfile_writeback: merges ALU/LSU results into the register-file write port and keeps the pending-rd scoreboard.
// Optional operand forwarding from the write port is enabled by defining RISCV_WB_FWD_EN.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_regfile_writeback (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_issue_valid,
    input  logic [4:0]        i_issue_rd_addr,
    input  logic [4:0]        i_rs1_addr,
    input  logic [4:0]        i_rs2_addr,
    output logic              o_rs1_busy,
    output logic              o_rs2_busy,
    output logic              o_rd_busy,
    input  logic              i_alu_valid,
    input  logic [4:0]        i_alu_rd_addr,
    input  logic [`XLEN-1:0]  i_alu_data,
    input  logic              i_lsu_valid,
    output logic              o_lsu_ready,
    input  logic [4:0]        i_lsu_rd_addr,
    input  logic [`XLEN-1:0]  i_lsu_data,
    output logic              o_regfile_rd_wen,
    output logic [4:0]        o_regfile_rd_addr,
    output logic [`XLEN-1:0]  o_regfile_rd_data,
`ifdef RISCV_WB_FWD_EN
    output logic              o_fwd_rs1_hit,
    output logic              o_fwd_rs2_hit,
    output logic [`XLEN-1:0]  o_fwd_rs1_data,
    output logic [`XLEN-1:0]  o_fwd_rs2_data,
`endif
    output logic              o_wb_err
);
    logic [31:0]       r_pending;
    logic [4:0]        r_fifo_addr [2];
    logic [`XLEN-1:0]  r_fifo_data [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;
    logic              r_wen;
    logic [4:0]        r_addr;
    logic [`XLEN-1:0]  r_data;
    logic              r_err;

    logic              w_empty;
    logic              w_push_req;
    logic              w_push;
    logic              w_pop;
    logic              w_sel_valid;
    logic [4:0]        w_sel_addr;
    logic [`XLEN-1:0]  w_sel_data;
    logic              w_sel_wr;
    logic [31:0]       w_clr;
    logic [31:0]       w_set;
    logic [31:0]       w_pend_nxt;
    logic              w_rs1_pend;
    logic              w_rs2_pend;

    assign w_empty     = (r_count == 2'd0);
    assign o_lsu_ready = (r_count != 2'd2);
    assign w_push_req  = i_lsu_valid && o_lsu_ready;

    // Priority: ALU, then oldest queued LSU entry, then a same-cycle LSU result bypassing the FIFO.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_addr  = 5'd0;
        w_sel_data  = '0;
        w_pop       = 1'b0;
        w_push      = w_push_req;
        if (i_alu_valid) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = i_alu_rd_addr;
            w_sel_data  = i_alu_data;
        end else if (!w_empty) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = r_fifo_addr[r_rptr];
            w_sel_data  = r_fifo_data[r_rptr];
            w_pop       = 1'b1;
        end else if (w_push_req) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = i_lsu_rd_addr;
            w_sel_data  = i_lsu_data;
            w_push      = 1'b0;
        end
    end

    assign w_sel_wr   = w_sel_valid && (w_sel_addr != 5'd0);
    assign w_clr      = r_wen ? (32'd1 << r_addr) : 32'd0;
    assign w_set      = i_issue_valid ? (32'd1 << i_issue_rd_addr) : 32'd0;
    assign w_pend_nxt = ((r_pending & ~w_clr) | w_set) & ~32'd1;

    assign w_rs1_pend = (i_rs1_addr != 5'd0) && r_pending[i_rs1_addr];
    assign w_rs2_pend = (i_rs2_addr != 5'd0) && r_pending[i_rs2_addr];
    assign o_rd_busy  = (i_issue_rd_addr != 5'd0) && r_pending[i_issue_rd_addr];

`ifdef RISCV_WB_FWD_EN
    assign o_fwd_rs1_hit  = r_wen && (r_addr == i_rs1_addr) && (i_rs1_addr != 5'd0);
    assign o_fwd_rs2_hit  = r_wen && (r_addr == i_rs2_addr) && (i_rs2_addr != 5'd0);
    assign o_fwd_rs1_data = r_data;
    assign o_fwd_rs2_data = r_data;
    assign o_rs1_busy     = w_rs1_pend && !o_fwd_rs1_hit;
    assign o_rs2_busy     = w_rs2_pend && !o_fwd_rs2_hit;
`else
    assign o_rs1_busy     = w_rs1_pend;
    assign o_rs2_busy     = w_rs2_pend;
`endif

    assign o_regfile_rd_wen  = r_wen;
    assign o_regfile_rd_addr = r_addr;
    assign o_regfile_rd_data = r_data;
    assign o_wb_err          = r_err;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_pending <= 32'd0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_count   <= 2'd0;
            r_wen     <= 1'b0;
            r_addr    <= 5'd0;
            r_data    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pending <= w_pend_nxt;
            r_wptr    <= r_wptr ^ w_push;
            r_rptr    <= r_rptr ^ w_pop;
            r_count   <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            r_wen     <= w_sel_wr;
            if (w_sel_valid) begin
                r_addr <= w_sel_addr;
                r_data <= w_sel_data;
            end
            if (w_sel_wr && !r_pending[w_sel_addr])
                r_err <= 1'b1;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= i_lsu_rd_addr;
            r_fifo_data[r_wptr] <= i_lsu_data;
        end
    end
endmodule

// File: tb/tb_riscv_regfile_writeback.sv
// tb_riscv_regfile_writeback: random and directed stimulus checked by a queue-based reference model and a write-port monitor.
module tb_riscv_regfile_writeback;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        rs1_busy, rs2_busy, rd_busy;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wb_err;
`ifdef RISCV_WB_FWD_EN
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
`endif

    always #5 clk = ~clk;

    riscv_regfile_writeback dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_issue_valid(issue_valid), .i_issue_rd_addr(issue_rd),
        .i_rs1_addr(rs1), .i_rs2_addr(rs2),
        .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy), .o_rd_busy(rd_busy),
        .i_alu_valid(alu_valid), .i_alu_rd_addr(alu_rd), .i_alu_data(alu_data),
        .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_ready), .i_lsu_rd_addr(lsu_rd), .i_lsu_data(lsu_data),
        .o_regfile_rd_wen(wen), .o_regfile_rd_addr(waddr), .o_regfile_rd_data(wdata),
`ifdef RISCV_WB_FWD_EN
        .o_fwd_rs1_hit(fwd1_hit), .o_fwd_rs2_hit(fwd2_hit),
        .o_fwd_rs1_data(fwd1_data), .o_fwd_rs2_data(fwd2_data),
`endif
        .o_wb_err(wb_err)
    );

    typedef struct { logic [4:0] a; logic [31:0] d; int due; } wr_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    wr_t         exp_q[$];
    logic [36:0] mq[$];
    bit          m_pend[32];
    bit          m_err = 0;
    bit          m_owen = 0;
    logic [4:0]  m_oaddr = '0;
    logic [31:0] m_odata = '0;
    bit          lsu_acc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every write seen on the port must be the oldest expected one, in the cycle it is due.
    always @(negedge clk) begin
        if (rstn) begin
            if (wen) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data %0h expected no write", waddr, wdata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", waddr, e.a);
                    chk("wr_data", wdata, e.d);
                    chk("wr_cycle", cyc, e.due);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                wr_t e;
                e = exp_q.pop_front();
                n_chk++;
                n_fail++;
                $display("FAIL missing_write: got no write expected addr %0d data %0h", e.a, e.d);
            end
        end
    end

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        foreach (m_pend[i]) m_pend[i] = 0;
        m_err = 0;
        m_owen = 0;
    endtask

    // One clock: check combinational outputs against the model, advance the model, then clock the DUT.
    task automatic step();
        logic [36:0] sel;
        bit sv, byp, rdy, h1, h2;
        wr_t e;
        #1;
        rdy = mq.size() < 2;
        h1 = m_owen && m_oaddr == rs1 && rs1 != 0;
        h2 = m_owen && m_oaddr == rs2 && rs2 != 0;
`ifndef RISCV_WB_FWD_EN
        h1 = 0;
        h2 = 0;
`endif
        chk("lsu_ready", lsu_ready, rdy);
        chk("rs1_busy", rs1_busy, rs1 != 0 && m_pend[rs1] && !h1);
        chk("rs2_busy", rs2_busy, rs2 != 0 && m_pend[rs2] && !h2);
        chk("rd_busy", rd_busy, issue_rd != 0 && m_pend[issue_rd]);
`ifdef RISCV_WB_FWD_EN
        chk("fwd_rs1_hit", fwd1_hit, h1);
        chk("fwd_rs2_hit", fwd2_hit, h2);
        if (h1) chk("fwd_rs1_data", fwd1_data, m_odata);
        if (h2) chk("fwd_rs2_data", fwd2_data, m_odata);
`endif
        sv = 0;
        byp = 0;
        sel = '0;
        lsu_acc = lsu_valid && rdy;
        if (alu_valid) begin
            sv = 1;
            sel = {alu_rd, alu_data};
        end else if (mq.size() > 0) begin
            sv = 1;
            sel = mq.pop_front();
        end else if (lsu_acc) begin
            sv = 1;
            byp = 1;
            sel = {lsu_rd, lsu_data};
        end
        if (lsu_acc && !byp) mq.push_back({lsu_rd, lsu_data});
        if (sv && sel[36:32] != 0) begin
            if (!m_pend[sel[36:32]]) m_err = 1;
            e.a = sel[36:32];
            e.d = sel[31:0];
            e.due = cyc + 1;
            exp_q.push_back(e);
        end
        if (m_owen) m_pend[m_oaddr] = 0;
        if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1;
        m_owen = sv && sel[36:32] != 0;
        if (sv) begin
            m_oaddr = sel[36:32];
            m_odata = sel[31:0];
        end
        @(posedge clk);
        @(negedge clk);
        chk("wb_err", wb_err, m_err);
    endtask

    task automatic drv(input bit iv, input logic [4:0] ird, input bit av, input logic [4:0] ard,
                       input logic [31:0] ad, input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
        issue_valid = iv;
        issue_rd = ird;
        alu_valid = av;
        alu_rd = ard;
        alu_data = ad;
        lsu_valid = lv;
        lsu_rd = lrd;
        lsu_data = ld;
        step();
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int pool[$];
        bit lv;
        logic [4:0] lrd;
        logic [31:0] ldat;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_lsu_ready", lsu_ready, 1);
        chk("rst_wen", wen, 0);
        chk("rst_addr", waddr, 0);
        chk("rst_data", wdata, 0);
        chk("rst_err", wb_err, 0);
        rstn = 1;

        // Reset and ALU write to x5
        rs1 = 5;
        rs2 = 0;
        drv(1, 5, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        idle();
        idle();

        // ALU/LSU collision
        drv(1, 3, 0, 0, 0, 0, 0, 0);
        drv(1, 4, 0, 0, 0, 0, 0, 0);
        rs1 = 3;
        rs2 = 4;
        drv(0, 0, 1, 3, 32'h11, 1, 4, 32'h22);
        repeat (3) idle();

        // FIFO full under an ALU burst
        foreach (pool[i]) pool.delete(i);
        for (int k = 0; k < 4; k++) drv(1, 5'(10 + k), 0, 0, 0, 0, 0, 0);
        for (int k = 6; k < 9; k++) drv(1, 5'(k), 0, 0, 0, 0, 0, 0);
        rs1 = 6;
        rs2 = 8;
        lv = 1;
        lrd = 6;
        for (int k = 0; k < 4; k++) begin
            drv(0, 0, 1, 5'(10 + k), 32'hA0 + k, lv, lrd, 32'h100 + lrd);
            if (lsu_acc) begin
                lrd++;
                if (lrd == 9) lv = 0;
            end
            if (k == 1) begin
                #1 chk("fifo_full_ready", lsu_ready, 0);
            end
        end
        while (lv) begin
            drv(0, 0, 0, 0, 0, lv, lrd, 32'h100 + lrd);
            if (lsu_acc) begin
                lrd++;
                if (lrd == 9) lv = 0;
            end
        end
        repeat (3) idle();

        // Same-edge set and clear of x2
        rs1 = 2;
        rs2 = 0;
        drv(1, 2, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 2, 32'h2222, 0, 0, 0);
        drv(1, 2, 0, 0, 0, 0, 0, 0);
        chk("x2_still_busy", rs1_busy, 1);
        idle();

        // rd=0 write, then write to non-pending x9
        rs1 = 9;
        drv(0, 0, 1, 0, 32'h5555, 0, 0, 0);
        chk("rd0_no_wen", wen, 0);
        chk("rd0_no_err", wb_err, 0);
        drv(0, 0, 1, 9, 32'h99, 0, 0, 0);
        chk("x9_err", wb_err, 1);
        idle();
        idle();
        chk("err_sticky", wb_err, 1);

        // Reset with two LSU entries queued
        for (int k = 20; k < 24; k++) drv(1, 5'(k), 0, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 23, 32'h23, 1, 20, 32'h20);
        drv(0, 0, 1, 22, 32'h22, 1, 21, 32'h21);
        chk("pre_rst_full", lsu_ready, 0);
        #2 rstn = 0;
        issue_valid = 0;
        alu_valid = 0;
        lsu_valid = 0;
        model_reset();
        #1;
        chk("midrst_ready", lsu_ready, 1);
        chk("midrst_wen", wen, 0);
        chk("midrst_err", wb_err, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1;
        rs1 = 20;
        rs2 = 21;
        repeat (4) idle();

        // Random traffic
        lv = 0;
        lrd = 0;
        ldat = 0;
        for (int n = 0; n < 400; n++) begin
            bit iv, av;
            logic [4:0] ird, ard;
            iv = ($urandom % 2) == 0;
            ird = 5'($urandom % 32);
            if (ird != 0 && m_pend[ird]) iv = 0;
            foreach (pool[i]) if (pool[i] == ird) iv = 0;
            av = 0;
            ard = 0;
            if (pool.size() > 0 && $urandom % 3 == 0) begin
                int idx;
                idx = $urandom % pool.size();
                av = 1;
                ard = 5'(pool[idx]);
                pool.delete(idx);
            end else if ($urandom % 16 == 0) begin
                av = 1;
            end
            if (!lv && pool.size() > 0 && $urandom % 2 == 0) begin
                int idx;
                idx = $urandom % pool.size();
                lv = 1;
                lrd = 5'(pool[idx]);
                ldat = $urandom;
                pool.delete(idx);
            end
            rs1 = 5'($urandom % 32);
            rs2 = 5'($urandom % 32);
            drv(iv, ird, av, ard, $urandom, lv, lrd, ldat);
            if (lv && lsu_acc) lv = 0;
            if (iv && ird != 0) pool.push_back(int'(ird));
        end
        while (lv) begin
            drv(0, 0, 0, 0, 0, 1, lrd, ldat);
            if (lsu_acc) lv = 0;
        end
        repeat (6) idle();
        chk("no_lost_writes", exp_q.size(), 0);
        chk("random_err", wb_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/riscv_regfile_writeback.md
# riscv_regfile_writeback

Write-back unit that owns the single write port of the integer register file. It merges results from the ALU and the load/store unit (LSU), queues LSU results in a 2-entry FIFO, and drives a registered write command to the register file. It also keeps a 32-bit pending-destination scoreboard that gives issue logic per-operand busy flags.

## Interface
- Parameters: none; data width is `XLEN from riscv_configs.v.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_issue_valid  in  1  an instruction writing rd issues this cycle.
- i_issue_rd_addr  in  5  destination of the issuing instruction.
- i_rs1_addr / i_rs2_addr  in  5 each  source registers checked for hazards.
- o_rs1_busy / o_rs2_busy  out  1 each  source register has a pending write.
- o_rd_busy  out  1  i_issue_rd_addr already pending (WAW check).
- i_alu_valid  in  1  ALU result present; always accepted, no ready.
- i_alu_rd_addr  in  5; i_alu_data  in  `XLEN.
- i_lsu_valid  in  1; o_lsu_ready  out  1; i_lsu_rd_addr  in  5; i_lsu_data  in  `XLEN.
- o_regfile_rd_wen  out  1; o_regfile_rd_addr  out  5; o_regfile_rd_data  out  `XLEN. These connect directly to the register file write port.
- o_wb_err  out  1  sticky: a result arrived for a register that was not pending.

## Operation
- Scoreboard: 32-bit pending vector; bit 0 is never set.
  - Set on i_issue_valid when i_issue_rd_addr != 0.
  - Cleared on any edge where o_regfile_rd_wen=1, at o_regfile_rd_addr.
  - Set and clear of the same address on the same edge: set wins.
- Busy flags: combinational lookup of the pending vector; address 0 always reads not busy.
- LSU FIFO:
  - 2 entries, each {rd_addr, data}.
  - o_lsu_ready = !full (combinational).
  - Push when i_lsu_valid && o_lsu_ready.
- Arbitration, evaluated each cycle. The chosen result is loaded into the output registers at the next edge.
  1. ALU, if i_alu_valid.
  2. Otherwise the FIFO head, if the FIFO is not empty (pop).
  3. Otherwise an LSU result pushed this same cycle is taken directly (FIFO bypass, no push).
  4. Otherwise o_regfile_rd_wen=0 next cycle.
- A selected result with rd_addr=0 is consumed (popped or accepted), but o_regfile_rd_wen stays 0.
- o_wb_err is set when a selected result with rd != 0 targets a register whose pending bit is 0. It clears only on reset.
- Simultaneous push and pop on a full FIFO cannot occur, because ready is low when the FIFO is full. Simultaneous push and pop on a non-full FIFO is allowed; occupancy is unchanged.
- Issue logic must not issue while o_rd_busy or a required rs busy flag is high. The block does not enforce this.

## Timing
- Reset (asynchronous, immediate):
  - o_regfile_rd_wen=0, o_regfile_rd_addr=0, o_regfile_rd_data=0.
  - Scoreboard cleared, FIFO emptied (contents discarded), o_wb_err=0.
  - Combinational outputs take their reset-derived values: o_lsu_ready=1, all busy flags=0.
- ALU latency: result at edge N appears on the rd_* outputs after edge N+1; the register file commits at edge N+2. The busy flag drops after edge N+2.
- LSU latency: 1 cycle through the bypass; each ALU result or older queued entry ahead of it adds 1 cycle.
- Write order: results reach the register file in arbitration order. Each LSU result stays in its arrival order relative to the other LSU results.
- Sustained ALU traffic starves the FIFO. o_lsu_ready drops after two queued entries; there is no data loss.

## Configuration
- Macro RISCV_WB_FWD_EN.
- When defined:
  - Adds o_fwd_rs1_hit, o_fwd_rs2_hit (1 bit each) and o_fwd_rs1_data, o_fwd_rs2_data (`XLEN each).
  - A hit is o_regfile_rd_wen && o_regfile_rd_addr==i_rsN_addr && i_rsN_addr!=0; the forwarded data is o_regfile_rd_data.
  - On a hit, o_rsN_busy is forced to 0 that cycle, one cycle earlier than without forwarding.
- When undefined:
  - These ports are absent.
  - Busy flags follow the scoreboard only.

## Test plan
- Reset and ALU write:
  - Stimulus: assert then release i_rstn; issue rd=5; one cycle later ALU writes rd=5, data 0xDEADBEEF.
  - Required: o_lsu_ready=1 after reset. Busy flag for x5 set the cycle after issue. wen=1, addr=5, data 0xDEADBEEF one cycle after ALU valid. x5 busy clears on the following edge.
- Collision:
  - Stimulus: ALU rd=3 (data 0x11) and LSU rd=4 (data 0x22) valid in the same cycle.
  - Required: rd_* outputs show 3/0x11, then 4/0x22 on the next cycle.
- FIFO full:
  - Stimulus: ALU valid on 4 consecutive cycles while LSU offers rd=6,7,8.
  - Required: o_lsu_ready=0 after two entries are queued. Writes to 6 then 7 follow the ALU burst; 8 is accepted only afterwards.
- rd=0 and errors:
  - Stimulus: ALU write to rd=0; ALU write to rd=9 with x9 not pending.
  - Required: the rd=0 write produces o_regfile_rd_wen=0 and o_wb_err stays 0. The rd=9 write is still performed and sets o_wb_err=1 from then on.
- Same-edge set/clear:
  - Stimulus: x2 is committing while a new issue of rd=2 occurs on the same edge.
  - Required: x2 stays busy.
- Reset mid-operation:
  - Stimulus: deassert i_rstn with 2 FIFO entries queued.
  - Required: the FIFO is emptied immediately and no write follows reset release.
- With RISCV_WB_FWD_EN defined:
  - Stimulus: i_rs1_addr=5 during the commit cycle of x5.
  - Required: o_fwd_rs1_hit=1, o_fwd_rs1_data=0xDEADBEEF, o_rs1_busy=0.
